// File: rtl/sp_pkg.sv
// Shared encodings and field positions for the ADC sampling path.
package sp_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  localparam int ADC_MSB = 15;
  localparam int ADC_LSB = 6;
  localparam int ADC_W   = 10;

  // Sample counter needs at least one bit even when no averaging is done.
  function automatic int cnt_width(input int avg_log2);
    return (avg_log2 < 1) ? 1 : avg_log2;
  endfunction
endpackage

// File: rtl/sample_accumulator.sv
// Running sum of 2^AVG_LOG2 conversions with terminal-count flag and averaged output.
module sample_accumulator
  import sp_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_add,
  input  logic             i_clear,
  input  logic [ADC_W-1:0] i_sample,
  output logic             o_last,
  output logic [ADC_W-1:0] o_avg
);
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = cnt_width(AVG_LOG2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_add) begin
      r_acc <= r_acc + ACC_W'(i_sample);
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_last = (r_cnt == LAST_CNT);
  // Dropping the low AVG_LOG2 bits is the truncating divide.
  assign o_avg  = r_acc[ACC_W-1:AVG_LOG2];
endmodule

// File: rtl/adc_sampler.sv
// DRP read sequencer for the panel-voltage ADC: one read per EOC, averaged output.
module adc_sampler
  import sp_pkg::*;
#(
  parameter int         AVG_LOG2 = 2,
  parameter logic [6:0] CHANNEL  = 7'h03,
  parameter int         TIMEOUT  = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EOC,
  input  logic             DRDY,
  input  logic [15:0]      DO,
  output logic             DEN,
  output logic [6:0]       DADDR,
  output logic [ADC_W-1:0] V_AVG,
  output logic             V_VALID,
  output logic             TOUT,
  output logic             OVR
);
  localparam int TC_W = $clog2(TIMEOUT);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [TC_W-1:0]  r_tcnt;
  logic [ADC_W-1:0] r_sample;
  logic             w_last;
  logic [ADC_W-1:0] w_avg;
  logic             w_unused_lsb;

  assign DADDR        = CHANNEL;
  assign w_unused_lsb = ^DO[ADC_LSB-1:0];

  sample_accumulator #(.AVG_LOG2(AVG_LOG2)) u_acc (
    .i_clk    (CLK),
    .i_rst    (RESET),
    .i_add    (r_state == S_ACC),
    .i_clear  (r_state == S_OUT),
    .i_sample (r_sample),
    .o_last   (w_last),
    .o_avg    (w_avg)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_tcnt   <= '0;
      r_sample <= '0;
      DEN      <= 1'b0;
      V_AVG    <= '0;
      V_VALID  <= 1'b0;
      TOUT     <= 1'b0;
      OVR      <= 1'b0;
    end else begin
      DEN     <= 1'b0;
      V_VALID <= 1'b0;
      TOUT    <= 1'b0;
      // A conversion arriving while a read is in flight is lost; remember it.
      if (EOC && r_state != S_IDLE) OVR <= 1'b1;
      case (r_state)
        S_IDLE: if (EOC) begin
          r_state <= S_REQ;
          DEN     <= 1'b1;
        end
        S_REQ: begin
          r_state <= S_WAIT;
          r_tcnt  <= '0;
        end
        S_WAIT: begin
          if (DRDY) begin
            r_sample <= DO[ADC_MSB:ADC_LSB];
            r_state  <= S_ACC;
          end else if (r_tcnt == TC_LAST) begin
            r_state <= S_IDLE;
            TOUT    <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + TC_W'(1);
          end
        end
        S_ACC: r_state <= w_last ? S_OUT : S_IDLE;
        S_OUT: begin
          V_AVG   <= w_avg;
          V_VALID <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_sampler.sv
// Scenario bench for adc_sampler; expected averages queued at stimulus time, popped on V_VALID.
module tb_adc_sampler;
  import sp_pkg::*;
  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        EOC = 1'b0;
  logic        DRDY = 1'b0;
  logic [15:0] DO = 16'h0;
  logic        DEN;
  logic [6:0]  DADDR;
  logic [9:0]  V_AVG;
  logic        V_VALID;
  logic        TOUT;
  logic        OVR;

  int n_cmp = 0;
  int n_err = 0;
  int den_cnt = 0;
  int tout_cnt = 0;
  int vv_cnt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] sb_exp;

  adc_sampler #(.AVG_LOG2(2), .CHANNEL(7'h03), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .EOC(EOC), .DRDY(DRDY), .DO(DO),
    .DEN(DEN), .DADDR(DADDR), .V_AVG(V_AVG), .V_VALID(V_VALID),
    .TOUT(TOUT), .OVR(OVR)
  );

  always #5 CLK = ~CLK;

  task automatic do_read(input logic [15:0] val, input int dly);
    @(negedge CLK); EOC = 1'b1;
    @(negedge CLK); EOC = 1'b0;
    repeat (dly) @(negedge CLK);
    DRDY = 1'b1; DO = val;
    @(negedge CLK); DRDY = 1'b0; DO = 16'h0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_cmp++; if ({DEN, V_VALID, TOUT, OVR} !== 4'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0000", {DEN, V_VALID, TOUT, OVR});
    end
    n_cmp++; if (V_AVG !== 10'd0) begin
      n_err++; $display("FAIL reset_vavg: got %0d expected 0", V_AVG);
    end
    n_cmp++; if (DADDR !== 7'h03) begin
      n_err++; $display("FAIL reset_daddr: got %h expected 03", DADDR);
    end
    RESET = 1'b0;
  endtask

  task automatic test_basic_avg();
    int d0, v0;
    d0 = den_cnt; v0 = vv_cnt;
    exp_q.push_back(10'd262);
    do_read(16'h4000, 3); do_read(16'h4100, 3);
    do_read(16'h4200, 3); do_read(16'h4300, 3);
    n_cmp++; if (den_cnt - d0 != 4) begin
      n_err++; $display("FAIL basic_den_pulses: got %0d expected 4", den_cnt - d0);
    end
    n_cmp++; if (vv_cnt - v0 != 1) begin
      n_err++; $display("FAIL basic_vvalid_pulses: got %0d expected 1", vv_cnt - v0);
    end
    n_cmp++; if (DADDR !== 7'h03) begin
      n_err++; $display("FAIL basic_daddr: got %h expected 03", DADDR);
    end
  endtask

  task automatic test_full_scale();
    exp_q.push_back(10'd1023);
    repeat (4) do_read(16'hFFC0, 2);
    exp_q.push_back(10'd0);
    repeat (4) do_read(16'h0000, 5);
  endtask

  task automatic test_timeout();
    int t0, v0, cyc;
    bit seen;
    t0 = tout_cnt; v0 = vv_cnt; cyc = 0; seen = 1'b0;
    @(negedge CLK); EOC = 1'b1;
    @(negedge CLK); EOC = 1'b0;
    @(negedge CLK);
    while (!seen && cyc < 4 * TIMEOUT) begin
      @(negedge CLK); cyc++;
      if (TOUT) seen = 1'b1;
    end
    n_cmp++; if (!seen || cyc != TIMEOUT) begin
      n_err++; $display("FAIL timeout_latency: got %0d (seen=%0d) expected %0d", cyc, seen, TIMEOUT);
    end
    @(negedge CLK);
    n_cmp++; if (TOUT !== 1'b0) begin
      n_err++; $display("FAIL timeout_width: got %b expected 0", TOUT);
    end
    repeat (2) @(negedge CLK);
    n_cmp++; if (tout_cnt - t0 != 1) begin
      n_err++; $display("FAIL timeout_pulses: got %0d expected 1", tout_cnt - t0);
    end
    n_cmp++; if (vv_cnt != v0 || V_AVG !== 10'd0) begin
      n_err++; $display("FAIL timeout_hold: vvalid %0d avg %0d expected %0d avg 0", vv_cnt, V_AVG, v0);
    end
    exp_q.push_back(10'd256);
    repeat (4) do_read(16'h4000, 3);
  endtask

  task automatic test_drdy_edges();
    int t0, v0, d0;
    v0 = vv_cnt;
    exp_q.push_back(10'd447);
    do_read(16'h4000, 1); do_read(16'h4000, 4);
    d0 = den_cnt;
    @(negedge CLK); DRDY = 1'b1; DO = 16'hFFC0;
    @(negedge CLK); DRDY = 1'b0; DO = 16'h0;
    repeat (4) @(negedge CLK);
    n_cmp++; if (vv_cnt != v0 || den_cnt != d0) begin
      n_err++; $display("FAIL stray_drdy: vvalid %0d den %0d expected %0d den %0d", vv_cnt, den_cnt, v0, d0);
    end
    t0 = tout_cnt;
    @(negedge CLK); EOC = 1'b1;
    @(negedge CLK); EOC = 1'b0;
    repeat (TIMEOUT) @(negedge CLK);
    DRDY = 1'b1; DO = 16'hFFC0;
    @(negedge CLK); DRDY = 1'b0; DO = 16'h0;
    n_cmp++; if (TOUT !== 1'b0) begin
      n_err++; $display("FAIL drdy_at_expiry_tout: got %b expected 0", TOUT);
    end
    repeat (3) @(negedge CLK);
    do_read(16'h4000, 3);
    repeat (2) @(negedge CLK);
    n_cmp++; if (tout_cnt != t0 || vv_cnt - v0 != 1) begin
      n_err++; $display("FAIL drdy_at_expiry_count: tout %0d vvalid %0d expected 0 and 1", tout_cnt - t0, vv_cnt - v0);
    end
  endtask

  task automatic test_overrun();
    int d0;
    n_cmp++; if (OVR !== 1'b0) begin
      n_err++; $display("FAIL ovr_before: got %b expected 0", OVR);
    end
    d0 = den_cnt;
    @(negedge CLK); EOC = 1'b1;
    @(negedge CLK); EOC = 1'b0;
    @(negedge CLK); EOC = 1'b1;
    @(negedge CLK); EOC = 1'b0;
    n_cmp++; if (OVR !== 1'b1) begin
      n_err++; $display("FAIL ovr_set: got %b expected 1", OVR);
    end
    repeat (2) @(negedge CLK);
    DRDY = 1'b1; DO = 16'h4000;
    @(negedge CLK); DRDY = 1'b0; DO = 16'h0;
    repeat (6) @(negedge CLK);
    n_cmp++; if (den_cnt - d0 != 1) begin
      n_err++; $display("FAIL ovr_den_pulses: got %0d expected 1", den_cnt - d0);
    end
    n_cmp++; if (OVR !== 1'b1 || V_AVG !== 10'd447) begin
      n_err++; $display("FAIL ovr_sticky: ovr %b avg %0d expected 1 avg 447", OVR, V_AVG);
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    do_read(16'h4000, 3); do_read(16'h4000, 3);
    @(negedge CLK); EOC = 1'b1;
    @(negedge CLK); EOC = 1'b0;
    repeat (2) @(negedge CLK);
    #1 RESET = 1'b1;
    #1;
    n_cmp++; if ({DEN, V_VALID, TOUT, OVR} !== 4'b0 || V_AVG !== 10'd0) begin
      n_err++; $display("FAIL midreset_outputs: flags %b avg %0d expected 0000 avg 0", {DEN, V_VALID, TOUT, OVR}, V_AVG);
    end
    repeat (2) @(negedge CLK);
    RESET = 1'b0; DRDY = 1'b1; DO = 16'hFFC0;
    @(negedge CLK); DRDY = 1'b0; DO = 16'h0;
    repeat (3) @(negedge CLK);
    v0 = vv_cnt;
    exp_q.push_back(10'd512);
    repeat (4) do_read(16'h8000, 3);
    n_cmp++; if (vv_cnt - v0 != 1) begin
      n_err++; $display("FAIL midreset_vvalid: got %0d expected 1", vv_cnt - v0);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge CLK);
        if (DEN) den_cnt++;
        if (TOUT) tout_cnt++;
        if (V_VALID) begin
          vv_cnt++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++; $display("FAIL scoreboard_unexpected: got V_AVG=%0d with nothing expected", V_AVG);
          end else begin
            sb_exp = exp_q.pop_front();
            if (V_AVG !== sb_exp) begin
              n_err++; $display("FAIL scoreboard_vavg: got %0d expected %0d", V_AVG, sb_exp);
            end
          end
        end
      end
    join_none
    test_reset();
    test_basic_avg();
    test_full_scale();
    test_timeout();
    test_drdy_edges();
    test_overrun();
    test_reset_mid();
    repeat (4) @(negedge CLK);
    n_cmp++; if (exp_q.size() != 0 || vv_cnt != 6) begin
      n_err++; $display("FAIL scoreboard_drain: pending %0d vvalid %0d expected 0 and 6", exp_q.size(), vv_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/adc_sampler.md
Name: adc_sampler

Overview:
- Upstream stage of the voltage visualiser/comparator path.
- Reads raw panel-voltage conversions from the on-chip ADC over its dynamic-reconfiguration port (DRP), one read per end-of-conversion strobe.
- Averages 2^AVG_LOG2 conversions and presents a stable 10-bit value with a one-cycle valid pulse, for the comparator and max-voltage register.
- Removes single-sample noise that would otherwise retrigger the max counter.

Parameters:
AVG_LOG2, 2, log2 of samples averaged per output (legal range 0..6)
CHANNEL, 7'h03, DRP register address read on every conversion
TIMEOUT, 16, maximum cycles in WAIT before abandoning a read (legal range ≥2)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
EOC  in  1  ADC end-of-conversion pulse, one cycle
DRDY  in  1  DRP data-ready, one cycle
DO  in  16  DRP read data; conversion result in DO[15:6]
DEN  out  1  DRP enable, one-cycle pulse
DADDR  out  7  DRP address
V_AVG  out  10  averaged voltage, held between updates
V_VALID  out  1  one-cycle pulse when V_AVG updates
TOUT  out  1  one-cycle pulse on read timeout
OVR  out  1  sticky overrun flag; cleared only by RESET

Behaviour:
- Reset values:
  - state=IDLE; acc=0; cnt=0; sample=0; tcnt=0.
  - DEN=0; DADDR=CHANNEL; V_AVG=0; V_VALID=0; TOUT=0; OVR=0.
- States: IDLE, REQ, WAIT, ACC, OUT. All outputs are registered.
- IDLE: EOC=1 at edge → REQ. DEN=1 during REQ. DADDR is constant CHANNEL.
- REQ: unconditional → WAIT. DEN=0. tcnt cleared.
- WAIT, DRDY=1: sample<=DO[15:6] → ACC.
- WAIT, DRDY=0: tcnt++. When tcnt reaches TIMEOUT-1 → IDLE with TOUT=1 for one cycle. The sample is dropped; acc and cnt are unchanged.
- ACC:
  - acc<=acc+sample; cnt<=cnt+1.
  - If cnt==2^AVG_LOG2-1 → OUT, else → IDLE.
- OUT:
  - V_AVG<=acc>>AVG_LOG2 (truncating); V_VALID=1 for this cycle only.
  - acc<=0; cnt<=0 → IDLE.
- Width rules:
  - acc is 10+AVG_LOG2 bits; it cannot overflow (max 1023·2^AVG_LOG2).
  - cnt is max(AVG_LOG2,1) bits.
- AVG_LOG2=0: every sample goes through ACC→OUT, and V_AVG equals the sample.
- Latency:
  - EOC sampled at edge t → DEN high in cycle t+1.
  - DRDY sampled at edge d → ACC at d+1 → OUT at d+2.
  - V_VALID and the new V_AVG appear together after edge d+2.
- EOC in any state other than IDLE: ignored (no new read) and OVR<=1.
- EOC and the return to IDLE on the same edge: the EOC is treated as overrun and not serviced.
- DRDY outside WAIT: ignored, with no flag.
- DRDY on the same edge as the timeout expiry: DRDY wins and the sample is taken; TOUT stays 0.
- RESET asserted mid-read or mid-average:
  - Immediate return to reset values, partial sum discarded.
  - Any DRDY still outstanding after release is ignored by the IDLE rule.
- V_AVG holds its last value indefinitely between updates, including across timeouts.

Decomposition:
- Shared package (sp_pkg):
  - state encodings: IDLE=3'd0, REQ=3'd1, WAIT=3'd2, ACC=3'd3, OUT=3'd4;
  - ADC_MSB=15, ADC_LSB=6;
  - ADC_W=10.
- One sub-module, sample_accumulator, is natural. It holds acc, cnt, the add/clear/shift datapath and the terminal-count flag (inputs: add, clear, sample; outputs: last, avg). The DRP handshake FSM stays in adc_sampler.

Test Plan:
1. AVG_LOG2=2: four EOCs with DRDY 3 cycles after DEN, DO=16'h4000,16'h4100,16'h4200,16'h4300 (256,260,264,268) → single V_VALID pulse, V_AVG=262, DEN pulses=4, DADDR=7'h03.
2. Four reads of DO=16'hFFC0 → V_AVG=1023 (no overflow). Next four reads of DO=16'h0000 → V_AVG=0.
3. EOC, then DRDY withheld → TOUT pulses exactly TIMEOUT cycles after entering WAIT. The next four good reads of 16'h4000 → V_AVG=256 (the timed-out read contributes nothing).
4. EOC re-asserted while in WAIT → OVR=1 and stays 1; only one DEN pulse is issued; OVR returns to 0 only after RESET.
5. RESET asserted (asynchronously, mid-cycle) after two of four samples → outputs go to reset values immediately. Four fresh reads of 16'h8000 → V_AVG=512.
6. DRDY coincident with the timeout-expiry edge → sample accepted, TOUT=0. Also: stray DRDY while in IDLE → no state change, no V_VALID.
